// File: rtl/lcd_frame_streamer_if.sv
// rtl/lcd_frame_streamer_if.sv - framebuffer read port and LCD SPI pin bundle
//
// Purpose: groups the framebuffer read handshake and the four LCD SPI pins
// so the streamer, the video RAM model and the panel share one connection.
// Ports (signals):
//   fb_rd    streamer -> RAM   read strobe
//   fb_addr  streamer -> RAM   read address (FB_AW bits)
//   fb_data  RAM -> streamer   read data (FB_BPP bits), valid 1 clk after fb_rd
//   LCD_CSX, LCD_DC, LCD_SCK, LCD_SDA  streamer -> panel
// Modports: master = streamer side, slave = RAM/panel side.
interface lcd_frame_streamer_if #(
  parameter int FB_AW  = 14,
  parameter int FB_BPP = 3
);
  logic              fb_rd;
  logic [FB_AW-1:0]  fb_addr;
  logic [FB_BPP-1:0] fb_data;
  logic              LCD_CSX;
  logic              LCD_DC;
  logic              LCD_SCK;
  logic              LCD_SDA;

  modport master (
    output fb_rd, fb_addr, LCD_CSX, LCD_DC, LCD_SCK, LCD_SDA,
    input  fb_data
  );

  modport slave (
    input  fb_rd, fb_addr, LCD_CSX, LCD_DC, LCD_SCK, LCD_SDA,
    output fb_data
  );
endinterface

// File: rtl/lcd_frame_streamer.sv
// rtl/lcd_frame_streamer.sv - framebuffer to SPI LCD frame streamer (RGB565)
//
// Purpose: while enabled, repeatedly sends CASET, RASET, RAMWR and then a full
// frame of RGB565 pixels read from a framebuffer, over a mode-0 SPI link.
// Optional feature macro: LCD_STREAM_TE_SYNC_EN adds the LCD_TE input and a
// TE_WAIT state so each frame starts on a tearing-effect rising edge.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   enable        level; start or keep refreshing frames
//   LCD_TE        tearing-effect input (only with LCD_STREAM_TE_SYNC_EN)
//   bus           master side of lcd_frame_streamer_if (framebuffer + SPI pins)
//   h_pos, v_pos  column/row of the pixel being sent
//   frame_start   1-clk pulse when CASET transmission begins
//   frame_done    1-clk pulse after the last pixel byte
//   busy          high whenever the state machine is not idle
module lcd_frame_streamer #(
  parameter int H_RES   = 80,
  parameter int V_RES   = 160,
  parameter int X_OFS   = 26,
  parameter int Y_OFS   = 1,
  parameter int FB_BPP  = 3,
  parameter int FB_AW   = 14,
  parameter int SCK_DIV = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
`ifdef LCD_STREAM_TE_SYNC_EN
  input  logic                 LCD_TE,
`endif
  lcd_frame_streamer_if.master bus,
  output logic [15:0]          h_pos,
  output logic [15:0]          v_pos,
  output logic                 frame_start,
  output logic                 frame_done,
  output logic                 busy
);

  localparam int DIV_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;
  localparam logic [15:0] XS = 16'(X_OFS);
  localparam logic [15:0] XE = 16'(X_OFS + H_RES - 1);
  localparam logic [15:0] YS = 16'(Y_OFS);
  localparam logic [15:0] YE = 16'(Y_OFS + V_RES - 1);

  generate
    if (FB_BPP != 3 && FB_BPP != 16) begin : g_bad_bpp
      $error("lcd_frame_streamer: FB_BPP must be 3 or 16");
    end
    if (H_RES * V_RES > (1 << FB_AW)) begin : g_bad_aw
      $error("lcd_frame_streamer: framebuffer does not fit in FB_AW address bits");
    end
    if (SCK_DIV < 1) begin : g_bad_div
      $error("lcd_frame_streamer: SCK_DIV must be at least 1");
    end
  endgenerate

  typedef enum logic [3:0] {
    S_IDLE, S_TE_WAIT, S_CASET, S_GAP_R, S_RASET, S_GAP_W, S_RAMWR, S_PIXEL, S_FRAME_END
  } state_t;

  state_t           state, state_n;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       phase;     // even = SCK low half, odd = SCK high half
  logic [2:0]       byte_cnt;  // byte index in a command; bit 0 = low byte in PIXEL
  logic [FB_AW-1:0] rd_addr;
  logic             rd_pend;
  logic [15:0]      next_word, pix_word, conv_word;
  logic [7:0]       tx_byte;
  logic             dc;
  logic             tick, byte_end, gap_end, first_cyc, in_byte, last_pix, fetch, pix_done;

  assign tick      = (div_cnt == DIV_W'(SCK_DIV - 1));
  assign byte_end  = tick && (phase == 4'd15);
  assign gap_end   = tick && (phase == 4'd1);
  assign first_cyc = (phase == 4'd0) && (div_cnt == '0);
  assign in_byte   = state inside {S_CASET, S_RASET, S_RAMWR, S_PIXEL};
  assign last_pix  = (h_pos == 16'(H_RES - 1)) && (v_pos == 16'(V_RES - 1));
  assign pix_done  = (state == S_PIXEL) && byte_end && byte_cnt[0];

`ifdef LCD_STREAM_TE_SYNC_EN
  logic [2:0] te_sync;
  logic       te_rise;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) te_sync <= '0;
    else     te_sync <= {te_sync[1:0], LCD_TE};
  end
  assign te_rise = te_sync[1] & ~te_sync[2];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: begin
        if (enable) begin
`ifdef LCD_STREAM_TE_SYNC_EN
          state_n = S_TE_WAIT;
`else
          state_n = S_CASET;
`endif
        end
      end
`ifdef LCD_STREAM_TE_SYNC_EN
      S_TE_WAIT: begin
        if (!enable)      state_n = S_IDLE;
        else if (te_rise) state_n = S_CASET;
      end
`endif
      S_CASET:     if (byte_end && byte_cnt == 3'd4) state_n = S_GAP_R;
      S_GAP_R:     if (gap_end) state_n = S_RASET;
      S_RASET:     if (byte_end && byte_cnt == 3'd4) state_n = S_GAP_W;
      S_GAP_W:     if (gap_end) state_n = S_RAMWR;
      S_RAMWR:     if (byte_end) state_n = S_PIXEL;
      S_PIXEL:     if (pix_done && last_pix) state_n = S_FRAME_END;
      S_FRAME_END: state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  // Bit timing restarts at every state change so each byte/gap begins aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      phase    <= '0;
      byte_cnt <= '0;
    end else if (state_n != state) begin
      div_cnt  <= '0;
      phase    <= '0;
      byte_cnt <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick)     phase    <= phase + 4'd1;
      if (byte_end) byte_cnt <= byte_cnt + 3'd1;
    end
  end

  always_comb begin
    tx_byte = 8'h00;
    dc      = 1'b1;
    case (state)
      S_CASET: begin
        case (byte_cnt)
          3'd0:    begin tx_byte = 8'h2A; dc = 1'b0; end
          3'd1:    tx_byte = XS[15:8];
          3'd2:    tx_byte = XS[7:0];
          3'd3:    tx_byte = XE[15:8];
          default: tx_byte = XE[7:0];
        endcase
      end
      S_RASET: begin
        case (byte_cnt)
          3'd0:    begin tx_byte = 8'h2B; dc = 1'b0; end
          3'd1:    tx_byte = YS[15:8];
          3'd2:    tx_byte = YS[7:0];
          3'd3:    tx_byte = YE[15:8];
          default: tx_byte = YE[7:0];
        endcase
      end
      S_RAMWR: begin
        tx_byte = 8'h2C;
        dc      = 1'b0;
      end
      S_PIXEL: tx_byte = byte_cnt[0] ? pix_word[7:0] : pix_word[15:8];
      default: ;
    endcase
  end

  generate
    if (FB_BPP == 16) begin : g_rgb565
      assign conv_word = bus.fb_data;
    end else begin : g_rgb111
      assign conv_word = {{5{bus.fb_data[2]}}, {6{bus.fb_data[1]}}, {5{bus.fb_data[0]}}};
    end
  endgenerate

  // One fetch per pixel, one pixel ahead: the RAMWR byte fetches pixel 0 and
  // each high byte fetches the following pixel (none after the last one).
  assign fetch = first_cyc &&
                 ((state == S_RAMWR) || ((state == S_PIXEL) && !byte_cnt[0] && !last_pix));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr   <= '0;
      rd_pend   <= 1'b0;
      next_word <= '0;
      pix_word  <= '0;
      h_pos     <= '0;
      v_pos     <= '0;
    end else begin
      rd_pend <= fetch;
      if (rd_pend) next_word <= conv_word;
      if (state == S_FRAME_END) rd_addr <= '0;
      else if (fetch)           rd_addr <= rd_addr + FB_AW'(1);
      if (((state == S_RAMWR) && byte_end) || pix_done) pix_word <= next_word;
      if (pix_done) begin
        if (last_pix) begin
          h_pos <= '0;
          v_pos <= '0;
        end else if (h_pos == 16'(H_RES - 1)) begin
          h_pos <= '0;
          v_pos <= v_pos + 16'd1;
        end else begin
          h_pos <= h_pos + 16'd1;
        end
      end
    end
  end

  assign bus.fb_rd   = fetch;
  assign bus.fb_addr = rd_addr;
  assign bus.LCD_CSX = ~in_byte;
  assign bus.LCD_DC  = dc;
  assign bus.LCD_SCK = in_byte & phase[0];
  assign bus.LCD_SDA = in_byte & tx_byte[3'd7 - phase[3:1]];
  assign frame_start = (state == S_CASET) && (byte_cnt == 3'd0) && first_cyc;
  assign frame_done  = (state == S_FRAME_END);
  assign busy        = (state != S_IDLE);

endmodule

// File: tb/tb_lcd_frame_streamer.sv
// tb/tb_lcd_frame_streamer.sv - directed self-checking bench for lcd_frame_streamer
module tb_lcd_frame_streamer;
  localparam int H = 4, V = 2, AW = 3, BPP = 3;
  localparam logic [7:0] EXP_B [27] = '{
    8'h2A, 8'h00, 8'h1A, 8'h00, 8'h1D,
    8'h2B, 8'h00, 8'h01, 8'h00, 8'h02,
    8'h2C,
    8'h00, 8'h00, 8'h00, 8'h1F, 8'h07, 8'hE0, 8'h07, 8'hFF,
    8'hF8, 8'h00, 8'hF8, 8'h1F, 8'hFF, 8'hE0, 8'hFF, 8'hFF};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, enable, enable3;
  logic [15:0] h1, v1, h3, v3;
  logic fs1, fd1, busy1, fs3, fd3, busy3;
  int errors = 0;
  int checks = 0;

  lcd_frame_streamer_if #(.FB_AW(AW), .FB_BPP(BPP)) bus1 ();
  lcd_frame_streamer_if #(.FB_AW(AW), .FB_BPP(BPP)) bus3 ();

`ifdef LCD_STREAM_TE_SYNC_EN
  logic te, te_auto_en, te_man;
  int te_cnt = 0;
  logic [31:0] te_cnt_v;
  always @(negedge clk) begin
    te_cnt++;
    te_cnt_v = te_cnt;
  end
  assign te = te_auto_en ? te_cnt_v[5] : te_man;
`endif

  lcd_frame_streamer #(.H_RES(H), .V_RES(V), .X_OFS(26), .Y_OFS(1), .FB_BPP(BPP),
                       .FB_AW(AW), .SCK_DIV(1)) dut (
    .clk(clk), .rst(rst), .enable(enable),
`ifdef LCD_STREAM_TE_SYNC_EN
    .LCD_TE(te),
`endif
    .bus(bus1), .h_pos(h1), .v_pos(v1), .frame_start(fs1), .frame_done(fd1), .busy(busy1));

  lcd_frame_streamer #(.H_RES(H), .V_RES(V), .X_OFS(26), .Y_OFS(1), .FB_BPP(BPP),
                       .FB_AW(AW), .SCK_DIV(3)) dut3 (
    .clk(clk), .rst(rst), .enable(enable3),
`ifdef LCD_STREAM_TE_SYNC_EN
    .LCD_TE(te),
`endif
    .bus(bus3), .h_pos(h3), .v_pos(v3), .frame_start(fs3), .frame_done(fd3), .busy(busy3));

  // Framebuffer model: word at address a is a[2:0], returned one clk after fb_rd.
  always @(posedge clk) begin
    if (bus1.fb_rd) bus1.fb_data <= bus1.fb_addr[2:0];
    if (bus3.fb_rd) bus3.fb_data <= bus3.fb_addr[2:0];
  end

  // SPI receiver for dut: samples SDA/DC on SCK rise, CSX high discards a partial byte.
  logic [7:0] rx_sh = 8'h00;
  int rx_n = 0;
  logic [7:0] rx_b [$];
  logic rx_dc [$];
  always @(posedge bus1.LCD_SCK or posedge bus1.LCD_CSX) begin
    if (bus1.LCD_CSX) rx_n = 0;
    else begin
      rx_sh = {rx_sh[6:0], bus1.LCD_SDA};
      rx_n++;
      if (rx_n == 8) begin
        rx_b.push_back(rx_sh);
        rx_dc.push_back(bus1.LCD_DC);
        rx_n = 0;
      end
    end
  end

  // Event monitors, sampled on the falling edge.
  int cyc = 0, fs1_cnt = 0, fd1_cnt = 0, csx_run = 0, sck3_run = 0;
  logic csx_q = 1'b1, sck3_q = 1'b0;
  int csx_runs [$];
  int rd_addrs [$];
  int fs3_cyc [$];
  int fd3_cyc [$];
  int sck3_rise [$];
  int sck3_hi [$];
  always @(negedge clk) begin
    cyc++;
    if (fs1) fs1_cnt++;
    if (fd1) fd1_cnt++;
    if (bus1.fb_rd) rd_addrs.push_back(int'(bus1.fb_addr));
    if (bus1.LCD_CSX) csx_run++;
    else begin
      if (csx_q) csx_runs.push_back(csx_run);
      csx_run = 0;
    end
    csx_q = bus1.LCD_CSX;
    if (fs3) fs3_cyc.push_back(cyc);
    if (fd3) fd3_cyc.push_back(cyc);
    if (bus3.LCD_SCK) begin
      if (!sck3_q) sck3_rise.push_back(cyc);
      sck3_run++;
    end else begin
      if (sck3_q) sck3_hi.push_back(sck3_run);
      sck3_run = 0;
    end
    sck3_q = bus3.LCD_SCK;
  end

  task automatic test_reset;
    rst = 1'b1;
    enable = 1'b0;
    enable3 = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus1.LCD_CSX !== 1'b1) begin errors++; $display("FAIL reset_csx got=%b want=1", bus1.LCD_CSX); end
    checks++; if (bus1.LCD_DC !== 1'b1) begin errors++; $display("FAIL reset_dc got=%b want=1", bus1.LCD_DC); end
    checks++; if (bus1.LCD_SCK !== 1'b0) begin errors++; $display("FAIL reset_sck got=%b want=0", bus1.LCD_SCK); end
    checks++; if (bus1.LCD_SDA !== 1'b0) begin errors++; $display("FAIL reset_sda got=%b want=0", bus1.LCD_SDA); end
    checks++; if (bus1.fb_rd !== 1'b0) begin errors++; $display("FAIL reset_fb_rd got=%b want=0", bus1.fb_rd); end
    checks++; if (bus1.fb_addr !== 3'd0) begin errors++; $display("FAIL reset_fb_addr got=%0d want=0", bus1.fb_addr); end
    checks++; if (h1 !== 16'd0 || v1 !== 16'd0) begin errors++; $display("FAIL reset_pos got=%0d,%0d want=0,0", h1, v1); end
    checks++; if (fs1 !== 1'b0 || fd1 !== 1'b0) begin errors++; $display("FAIL reset_pulses got=%b%b want=00", fs1, fd1); end
    checks++; if (busy1 !== 1'b0 || busy3 !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b%b want=00", busy1, busy3); end
    @(negedge clk) rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy1 !== 1'b0) begin errors++; $display("FAIL idle_no_enable busy got=%b want=0", busy1); end
  endtask

  task automatic test_frame;
    int b0, r0, a0, fd0, fs0, n;
    b0 = rx_b.size(); r0 = csx_runs.size(); a0 = rd_addrs.size(); fd0 = fd1_cnt; fs0 = fs1_cnt;
    @(negedge clk) enable = 1'b1;
    n = 0;
    while (fd1 !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    enable = 1'b0;
    checks++; if (n >= 3000) begin errors++; $display("FAIL frame_timeout waited=%0d want<3000", n); end
    repeat (20) @(negedge clk);
    checks++; if (rx_b.size() - b0 != 27) begin errors++; $display("FAIL frame_byte_count got=%0d want=27", rx_b.size() - b0); end
    for (int i = 0; i < 27 && b0 + i < rx_b.size(); i++) begin
      checks++;
      if (rx_b[b0+i] !== EXP_B[i] || rx_dc[b0+i] !== ((i == 0 || i == 5 || i == 10) ? 1'b0 : 1'b1)) begin
        errors++; $display("FAIL frame_byte[%0d] got=%h dc=%b want=%h", i, rx_b[b0+i], rx_dc[b0+i], EXP_B[i]);
      end
    end
    checks++; if (csx_runs.size() - r0 != 3) begin errors++; $display("FAIL csx_fall_count got=%0d want=3", csx_runs.size() - r0); end
    else begin
      checks++; if (csx_runs[r0+1] != 2 || csx_runs[r0+2] != 2) begin errors++; $display("FAIL csx_gap got=%0d,%0d want=2,2", csx_runs[r0+1], csx_runs[r0+2]); end
    end
    checks++; if (rd_addrs.size() - a0 != 8) begin errors++; $display("FAIL fb_rd_count got=%0d want=8", rd_addrs.size() - a0); end
    for (int i = 0; i < 8 && a0 + i < rd_addrs.size(); i++) begin
      checks++; if (rd_addrs[a0+i] != i) begin errors++; $display("FAIL fb_addr[%0d] got=%0d want=%0d", i, rd_addrs[a0+i], i); end
    end
    checks++; if (fd1_cnt - fd0 != 1 || fs1_cnt - fs0 != 1) begin errors++; $display("FAIL frame_pulses got start=%0d done=%0d want=1,1", fs1_cnt - fs0, fd1_cnt - fd0); end
    checks++; if (busy1 !== 1'b0 || h1 !== 16'd0 || v1 !== 16'd0) begin errors++; $display("FAIL frame_end_state got busy=%b h=%0d v=%0d want=0,0,0", busy1, h1, v1); end
  endtask

  task automatic test_enable_drop;
    int b0, fs0, fd0, n;
    b0 = rx_b.size(); fs0 = fs1_cnt; fd0 = fd1_cnt;
    @(negedge clk) enable = 1'b1;
    n = 0;
    while (!(busy1 === 1'b1 && h1 === 16'd3 && v1 === 16'd0) && n < 3000) begin @(negedge clk); n++; end
    enable = 1'b0;
    checks++; if (n >= 3000) begin errors++; $display("FAIL drop_reach_pixel3 waited=%0d want<3000", n); end
    n = 0;
    while (fd1 !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    repeat (60) @(negedge clk);
    checks++; if (rx_b.size() - b0 != 27) begin errors++; $display("FAIL drop_byte_count got=%0d want=27", rx_b.size() - b0); end
    else begin
      checks++; if (rx_b[b0+25] !== 8'hFF || rx_b[b0+26] !== 8'hFF) begin errors++; $display("FAIL drop_last_pixel got=%h%h want=FFFF", rx_b[b0+25], rx_b[b0+26]); end
    end
    checks++; if (fs1_cnt - fs0 != 1 || fd1_cnt - fd0 != 1) begin errors++; $display("FAIL drop_frames got start=%0d done=%0d want=1,1", fs1_cnt - fs0, fd1_cnt - fd0); end
    checks++; if (busy1 !== 1'b0 || bus1.LCD_CSX !== 1'b1) begin errors++; $display("FAIL drop_idle got busy=%b csx=%b want=0,1", busy1, bus1.LCD_CSX); end
  endtask

  task automatic test_reset_mid;
    int b0, b1, fs0, n;
    b0 = rx_b.size();
    @(negedge clk) enable = 1'b1;
    n = 0;
    while (rx_b.size() - b0 < 7 && n < 3000) begin @(negedge clk); n++; end
    repeat (3) @(negedge clk);
    checks++; if (bus1.LCD_CSX !== 1'b0 || n >= 3000) begin errors++; $display("FAIL mid_raset_active got csx=%b waited=%0d want csx=0", bus1.LCD_CSX, n); end
    rst = 1'b1;
    #1;
    checks++; if (bus1.LCD_CSX !== 1'b1 || bus1.LCD_SCK !== 1'b0 || busy1 !== 1'b0) begin
      errors++; $display("FAIL mid_reset_outputs got csx=%b sck=%b busy=%b want=1,0,0", bus1.LCD_CSX, bus1.LCD_SCK, busy1);
    end
    checks++; if (bus1.LCD_SDA !== 1'b0 || bus1.LCD_DC !== 1'b1 || bus1.fb_rd !== 1'b0) begin
      errors++; $display("FAIL mid_reset_misc got sda=%b dc=%b fb_rd=%b want=0,1,0", bus1.LCD_SDA, bus1.LCD_DC, bus1.fb_rd);
    end
    @(negedge clk) rst = 1'b0;
    b1 = rx_b.size(); fs0 = fs1_cnt;
    checks++; if (h1 !== 16'd0 || v1 !== 16'd0) begin errors++; $display("FAIL mid_reset_pos got=%0d,%0d want=0,0", h1, v1); end
    n = 0;
    while (fd1 !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    enable = 1'b0;
    repeat (20) @(negedge clk);
    checks++; if (rx_b.size() - b1 != 27) begin errors++; $display("FAIL restart_byte_count got=%0d want=27", rx_b.size() - b1); end
    else begin
      checks++; if (rx_b[b1] !== 8'h2A || rx_dc[b1] !== 1'b0) begin errors++; $display("FAIL restart_first got=%h dc=%b want=2A dc=0", rx_b[b1], rx_dc[b1]); end
    end
    checks++; if (fs1_cnt - fs0 != 1) begin errors++; $display("FAIL restart_frame_start got=%0d want=1", fs1_cnt - fs0); end
  endtask

  task automatic test_sck_div3;
    int s0, d0, k0, h0, n;
    s0 = fs3_cyc.size(); d0 = fd3_cyc.size(); k0 = sck3_rise.size(); h0 = sck3_hi.size();
    @(negedge clk) enable3 = 1'b1;
    n = 0;
`ifdef LCD_STREAM_TE_SYNC_EN
    while (fd3_cyc.size() - d0 < 1 && n < 5000) begin @(negedge clk); n++; end
`else
    while (fs3_cyc.size() - s0 < 2 && n < 5000) begin @(negedge clk); n++; end
`endif
    enable3 = 1'b0;
    checks++; if (n >= 5000) begin errors++; $display("FAIL div3_timeout waited=%0d want<5000", n); end
    n = 0;
    while (busy3 !== 1'b0 && n < 3000) begin @(negedge clk); n++; end
    checks++; if (sck3_hi.size() - h0 < 1 || sck3_hi[h0] != 3) begin errors++; $display("FAIL div3_sck_high got=%0d want=3", (sck3_hi.size() > h0) ? sck3_hi[h0] : -1); end
    checks++; if (sck3_rise.size() - k0 < 9) begin errors++; $display("FAIL div3_sck_count got=%0d want>=9", sck3_rise.size() - k0); end
    else begin
      checks++; if (sck3_rise[k0+1] - sck3_rise[k0] != 6) begin errors++; $display("FAIL div3_sck_period got=%0d want=6", sck3_rise[k0+1] - sck3_rise[k0]); end
      checks++; if (sck3_rise[k0+8] - sck3_rise[k0] != 48) begin errors++; $display("FAIL div3_byte_period got=%0d want=48", sck3_rise[k0+8] - sck3_rise[k0]); end
    end
    checks++; if (fs3_cyc.size() - s0 < 1 || fd3_cyc.size() - d0 < 1) begin errors++; $display("FAIL div3_pulses got start=%0d done=%0d want>=1", fs3_cyc.size() - s0, fd3_cyc.size() - d0); end
    else begin
      checks++; if (fd3_cyc[d0] - fs3_cyc[s0] != 1308) begin errors++; $display("FAIL div3_start_to_done got=%0d want=1308", fd3_cyc[d0] - fs3_cyc[s0]); end
    end
`ifndef LCD_STREAM_TE_SYNC_EN
    checks++; if (fs3_cyc.size() - s0 < 2 || fs3_cyc[s0+1] - fs3_cyc[s0] != 1310) begin
      errors++; $display("FAIL div3_frame_period got=%0d want=1310", (fs3_cyc.size() - s0 >= 2) ? fs3_cyc[s0+1] - fs3_cyc[s0] : -1);
    end
`endif
  endtask

`ifdef LCD_STREAM_TE_SYNC_EN
  task automatic test_te_sync;
    int fs0, n;
    te_auto_en = 1'b0;
    te_man = 1'b0;
    repeat (10) @(negedge clk);
    fs0 = fs1_cnt;
    enable = 1'b1;
    repeat (100) @(negedge clk);
    checks++; if (fs1_cnt != fs0 || busy1 !== 1'b1) begin errors++; $display("FAIL te_wait got starts=%0d busy=%b want=0,1", fs1_cnt - fs0, busy1); end
    te_man = 1'b1;
    n = 0;
    while (fs1 !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    checks++; if (n > 4) begin errors++; $display("FAIL te_latency got=%0d want<=4", n); end
    repeat (200) @(negedge clk);
    te_man = 1'b0;
    repeat (3) @(negedge clk);
    te_man = 1'b1;
    n = 0;
    while (fd1 !== 1'b1 && n < 3000) begin @(negedge clk); n++; end
    enable = 1'b0;
    repeat (30) @(negedge clk);
    checks++; if (fs1_cnt - fs0 != 1 || busy1 !== 1'b0) begin errors++; $display("FAIL te_mid_frame got starts=%0d busy=%b want=1,0", fs1_cnt - fs0, busy1); end
    te_auto_en = 1'b1;
  endtask
`endif

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    enable3 = 1'b0;
`ifdef LCD_STREAM_TE_SYNC_EN
    te_auto_en = 1'b1;
    te_man = 1'b0;
`endif
    test_reset();
    test_frame();
    test_enable_drop();
    test_reset_mid();
    test_sck_div3();
`ifdef LCD_STREAM_TE_SYNC_EN
    test_te_sync();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
